// File: rtl/triangle_dispatcher.sv
// -----------------------------------------------------------------------------
// triangle_dispatcher
//
// Queued initiator that feeds triangles to the shader. The host fills a
// ten-word staging set (nine vertex coordinates plus colour) and pushes it
// into a circular triangle queue. The dispatcher pops one entry at a time,
// presents it on the shader's vertex/colour inputs, pulses start and holds
// everything stable until the shader reports done.
//
// Optional feature macro: DEGENERATE_CULL_EN
//   defined   -> CHECK computes twice the signed triangle area from the
//                x/y coordinates and drops zero-area triangles (cull_count++)
//   undefined -> CHECK always passes to ISSUE, cull_count is tied to 0
//   Cycle timing is the same in both builds.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data staging word write (0..8 vertices, 9 colour)
//   push                  enqueue the staging set as it stood before the edge
//   q_full/q_empty        queue status
//   q_count               occupied queue entries
//   overflow              sticky, set by a push that found the queue full
//   v1x..v3z, pixel_color triangle presented to the shader
//   start                 one-cycle start pulse to the shader
//   shader_done           shader completion pulse (honoured only in WAIT)
//   busy                  high whenever the FSM is not in IDLE
//   tri_done_count        completed triangles (wraps)
//   cull_count            culled triangles (wraps)
//   dbg_state             current FSM state encoding
//
// Shader handshake: start is asserted for exactly one cycle (the ISSUE
// state) with the triangle already stable on v*/pixel_color; the triangle
// stays stable until the single-cycle shader_done is seen in WAIT. A new
// start is never issued before that done has been observed.
// -----------------------------------------------------------------------------
module triangle_dispatcher #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic [3:0]    wr_addr,
   input  logic [15:0]   wr_data,
   input  logic          push,
   output logic          q_full,
   output logic          q_empty,
   output logic [CW-1:0] q_count,
   output logic          overflow,
   output logic [15:0]   v1x,
   output logic [15:0]   v1y,
   output logic [15:0]   v1z,
   output logic [15:0]   v2x,
   output logic [15:0]   v2y,
   output logic [15:0]   v2z,
   output logic [15:0]   v3x,
   output logic [15:0]   v3y,
   output logic [15:0]   v3z,
   output logic [15:0]   pixel_color,
   output logic          start,
   input  logic          shader_done,
   output logic          busy,
   output logic [15:0]   tri_done_count,
   output logic [15:0]   cull_count,
   output logic [2:0]    dbg_state
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_ISSUE = 3'd3,
      S_WAIT  = 3'd4
   } state_t;

   state_t r_state;

   // ---------------------------------------------------------------------------
   // Staging registers
   // ---------------------------------------------------------------------------
   logic [15:0]  r_stage [10];
   logic [159:0] w_stage_flat;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 10; i++) r_stage[i] <= '0;
      end else if (wr_en && (wr_addr <= 4'd9)) begin
         r_stage[wr_addr] <= wr_data;
      end
   end

   // Word i of a queue entry lives at bits [16*i +: 16].
   always_comb begin
      w_stage_flat = '0;
      for (int i = 0; i < 10; i++) w_stage_flat[16*i +: 16] = r_stage[i];
   end

   // ---------------------------------------------------------------------------
   // Triangle queue
   // ---------------------------------------------------------------------------
   logic [159:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   logic          w_full;
   logic          w_pop;
   logic          w_push_ok;
   logic [159:0]  w_head;

   assign w_full    = (r_count == CW'(DEPTH));
   // The FSM only enters LOAD from IDLE with a non-empty queue, so LOAD
   // always has a valid head to pop.
   assign w_pop     = (r_state == S_LOAD);
   // A pop on the same edge frees a slot, so a push into a full queue is
   // still accepted in that cycle.
   assign w_push_ok = push && (!w_full || w_pop);
   assign w_head    = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= w_stage_flat;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push_ok && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push_ok && w_pop) r_count <= r_count - CW'(1);
         if (push && !w_push_ok) r_overflow <= 1'b1;
      end
   end

   assign q_full   = w_full;
   assign q_empty  = (r_count == '0);
   assign q_count  = r_count;
   assign overflow = r_overflow;

   // ---------------------------------------------------------------------------
   // Dispatch FSM with registered outputs
   // ---------------------------------------------------------------------------
   logic [15:0] r_v1x, r_v1y, r_v1z;
   logic [15:0] r_v2x, r_v2y, r_v2z;
   logic [15:0] r_v3x, r_v3y, r_v3z;
   logic [15:0] r_color;
   logic        r_start;
   logic [15:0] r_tri_done;
   logic        w_cull;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_v1x      <= '0;
         r_v1y      <= '0;
         r_v1z      <= '0;
         r_v2x      <= '0;
         r_v2y      <= '0;
         r_v2z      <= '0;
         r_v3x      <= '0;
         r_v3y      <= '0;
         r_v3z      <= '0;
         r_color    <= '0;
         r_start    <= 1'b0;
         r_tri_done <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_count != '0) r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_v1x   <= w_head[  0 +: 16];
               r_v1y   <= w_head[ 16 +: 16];
               r_v1z   <= w_head[ 32 +: 16];
               r_v2x   <= w_head[ 48 +: 16];
               r_v2y   <= w_head[ 64 +: 16];
               r_v2z   <= w_head[ 80 +: 16];
               r_v3x   <= w_head[ 96 +: 16];
               r_v3y   <= w_head[112 +: 16];
               r_v3z   <= w_head[128 +: 16];
               r_color <= w_head[144 +: 16];
               r_state <= S_CHECK;
            end
            S_CHECK: begin
               if (w_cull) begin
                  r_state <= S_IDLE;
               end else begin
                  // start is registered so it is high exactly while in ISSUE.
                  r_start <= 1'b1;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_start <= 1'b0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (shader_done) begin
                  r_tri_done <= r_tri_done + 16'd1;
                  r_state    <= S_IDLE;
               end
            end
            default: begin
               r_start <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Degenerate-triangle culling
   // ---------------------------------------------------------------------------
`ifdef DEGENERATE_CULL_EN
   logic signed [16:0] w_dx21, w_dy21, w_dx31, w_dy31;
   logic signed [33:0] w_prod_a, w_prod_b;
   logic signed [34:0] w_area2;
   logic [15:0]        r_cull_count;

   // Coordinates are unsigned, so zero-extend before differencing to keep
   // the full 17-bit signed range.
   assign w_dx21   = $signed({1'b0, r_v2x}) - $signed({1'b0, r_v1x});
   assign w_dy21   = $signed({1'b0, r_v2y}) - $signed({1'b0, r_v1y});
   assign w_dx31   = $signed({1'b0, r_v3x}) - $signed({1'b0, r_v1x});
   assign w_dy31   = $signed({1'b0, r_v3y}) - $signed({1'b0, r_v1y});
   assign w_prod_a = 34'(w_dx21) * 34'(w_dy31);
   assign w_prod_b = 34'(w_dx31) * 34'(w_dy21);
   assign w_area2  = 35'(w_prod_a) - 35'(w_prod_b);
   assign w_cull   = (w_area2 == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cull_count <= '0;
      end else if ((r_state == S_CHECK) && w_cull) begin
         r_cull_count <= r_cull_count + 16'd1;
      end
   end

   assign cull_count = r_cull_count;
`else
   assign w_cull     = 1'b0;
   assign cull_count = 16'd0;
`endif

   // ---------------------------------------------------------------------------
   // Output mapping
   // ---------------------------------------------------------------------------
   assign v1x            = r_v1x;
   assign v1y            = r_v1y;
   assign v1z            = r_v1z;
   assign v2x            = r_v2x;
   assign v2y            = r_v2y;
   assign v2z            = r_v2z;
   assign v3x            = r_v3x;
   assign v3y            = r_v3y;
   assign v3z            = r_v3z;
   assign pixel_color    = r_color;
   assign start          = r_start;
   assign busy           = (r_state != S_IDLE);
   assign tri_done_count = r_tri_done;
   assign dbg_state      = r_state;

endmodule

// File: tb/tb_triangle_dispatcher.sv
module tb_triangle_dispatcher;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        push;
  logic        q_full;
  logic        q_empty;
  logic [2:0]  q_count;
  logic        overflow;
  logic [15:0] v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z;
  logic [15:0] pixel_color;
  logic        start;
  logic        shader_done;
  logic        busy;
  logic [15:0] tri_done_count;
  logic [15:0] cull_count;
  logic [2:0]  dbg_state;

  int tests_run = 0;
  int fails     = 0;
  int start_cnt = 0;

  triangle_dispatcher #(.DEPTH(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .push           (push),
    .q_full         (q_full),
    .q_empty        (q_empty),
    .q_count        (q_count),
    .overflow       (overflow),
    .v1x            (v1x),
    .v1y            (v1y),
    .v1z            (v1z),
    .v2x            (v2x),
    .v2y            (v2y),
    .v2z            (v2z),
    .v3x            (v3x),
    .v3y            (v3y),
    .v3z            (v3z),
    .pixel_color    (pixel_color),
    .start          (start),
    .shader_done    (shader_done),
    .busy           (busy),
    .tri_done_count (tri_done_count),
    .cull_count     (cull_count),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each start pulse spans exactly one falling edge.
  always @(negedge clk) if (start === 1'b1) start_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic write_word(input logic [3:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic load_stage(input logic [15:0] x1, y1, z1, x2, y2, z2,
                            x3, y3, z3, c);
    write_word(4'd0, x1); write_word(4'd1, y1); write_word(4'd2, z1);
    write_word(4'd3, x2); write_word(4'd4, y2); write_word(4'd5, z2);
    write_word(4'd6, x3); write_word(4'd7, y3); write_word(4'd8, z3);
    write_word(4'd9, c);
  endtask

  task automatic do_push();
    push = 1'b1;
    tick();
    push = 1'b0;
  endtask

  task automatic pulse_done();
    shader_done = 1'b1;
    tick();
    shader_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] got [10];
    got = '{v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z, pixel_color};
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (got[i] !== 16'h0000) begin
        fails++; $display("FAIL reset_word%0d: got %h expected 0000", i, got[i]);
      end
    end
    tests_run++;
    if ({start, busy, overflow, q_full, q_empty} !== 5'b00001) begin
      fails++; $display("FAIL reset_flags: got %b expected 00001", {start, busy, overflow, q_full, q_empty});
    end
    tests_run++;
    if (q_count !== 3'd0) begin
      fails++; $display("FAIL reset_count: got %0d expected 0", q_count);
    end
    tests_run++;
    if ({tri_done_count, cull_count} !== 32'h0) begin
      fails++; $display("FAIL reset_counters: got %h expected 0", {tri_done_count, cull_count});
    end
    tests_run++;
    if (dbg_state !== ST_IDLE) begin
      fails++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_single();
    logic [15:0] exp_w [10];
    logic [15:0] got [10];
    logic        exp_start [4];
    exp_w = '{16'h0020, 16'h0040, 16'h0001, 16'h0200, 16'h0100, 16'h0002,
              16'h0040, 16'h0300, 16'h0003, 16'h0002};
    exp_start = '{1'b0, 1'b0, 1'b0, 1'b1};
    load_stage(exp_w[0], exp_w[1], exp_w[2], exp_w[3], exp_w[4],
               exp_w[5], exp_w[6], exp_w[7], exp_w[8], exp_w[9]);
    do_push();  // E0
    tests_run++;
    if (q_count !== 3'd1) begin
      fails++; $display("FAIL single_count_after_push: got %0d expected 1", q_count);
    end
    // Sample after E0, E1, E2, E3: start only after E3.
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      tests_run++;
      if (start !== exp_start[k]) begin
        fails++; $display("FAIL single_start_E%0d: got %b expected %b", k, start, exp_start[k]);
      end
    end
    tests_run++;
    if (dbg_state !== ST_ISSUE) begin
      fails++; $display("FAIL single_state_issue: got %0d expected %0d", dbg_state, ST_ISSUE);
    end
    tick();  // E4 -> WAIT
    tests_run++;
    if (start !== 1'b0) begin
      fails++; $display("FAIL single_start_E4: got %b expected 0", start);
    end
    got = '{v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z, pixel_color};
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (got[i] !== exp_w[i]) begin
        fails++; $display("FAIL single_word%0d: got %h expected %h", i, got[i], exp_w[i]);
      end
    end
    // Shader stalled: outputs stay put and state stays WAIT.
    for (int k = 0; k < 5; k++) begin
      tick();
      tests_run++;
      if ({v1x, v3z, pixel_color, start, busy, dbg_state} !==
          {exp_w[0], exp_w[8], exp_w[9], 1'b0, 1'b1, ST_WAIT}) begin
        fails++; $display("FAIL single_hold%0d: got %h/%h/%h start=%b busy=%b st=%0d", k,
                          v1x, v3z, pixel_color, start, busy, dbg_state);
      end
    end
    pulse_done();
    tests_run++;
    if (tri_done_count !== 16'd1) begin
      fails++; $display("FAIL single_done_count: got %0d expected 1", tri_done_count);
    end
    tests_run++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      fails++; $display("FAIL single_busy_fall: got busy=%b st=%0d expected 0/0", busy, dbg_state);
    end
  endtask

  task automatic test_done_idle();
    pulse_done();
    tick();
    tests_run++;
    if (tri_done_count !== 16'd1) begin
      fails++; $display("FAIL done_idle_count: got %0d expected 1", tri_done_count);
    end
    tests_run++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      fails++; $display("FAIL done_idle_state: got busy=%b st=%0d expected 0/0", busy, dbg_state);
    end
  endtask

  // Five pushes on consecutive edges; each push also rewrites the colour
  // word, so entry k carries colour k+1 only if push samples pre-write data.
  task automatic test_back_to_back();
    int s0;
    apply_reset();
    load_stage(16'h0020, 16'h0040, 16'h0001, 16'h0200, 16'h0100, 16'h0002,
               16'h0040, 16'h0300, 16'h0003, 16'h0001);
    s0 = start_cnt;
    for (int k = 0; k < 5; k++) begin
      push    = 1'b1;
      wr_en   = 1'b1;
      wr_addr = 4'd9;
      wr_data = 16'(k + 2);
      tick();
    end
    push  = 1'b0;
    wr_en = 1'b0;
    tests_run++;
    if (q_count !== 3'd4 || q_full !== 1'b1) begin
      fails++; $display("FAIL b2b_count: got %0d full=%b expected 4/1", q_count, q_full);
    end
    tests_run++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL b2b_overflow: got %b expected 0", overflow);
    end
    tests_run++;
    if (pixel_color !== 16'd1 || dbg_state !== ST_WAIT) begin
      fails++; $display("FAIL b2b_entry1: got colour %0d st=%0d expected 1/%0d", pixel_color, dbg_state, ST_WAIT);
    end
    repeat (3) tick();
    tests_run++;
    if (start_cnt - s0 !== 1) begin
      fails++; $display("FAIL b2b_starts: got %0d expected 1", start_cnt - s0);
    end
  endtask

  task automatic test_push_pop_full();
    pulse_done();  // -> IDLE
    tick();        // -> LOAD
    tests_run++;
    if (dbg_state !== ST_LOAD || q_count !== 3'd4) begin
      fails++; $display("FAIL ppf_pre: got st=%0d count=%0d expected %0d/4", dbg_state, q_count, ST_LOAD);
    end
    push = 1'b1;
    tick();        // pop and push on the same edge
    push = 1'b0;
    tests_run++;
    if (q_count !== 3'd4 || q_full !== 1'b1) begin
      fails++; $display("FAIL ppf_count: got %0d full=%b expected 4/1", q_count, q_full);
    end
    tests_run++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL ppf_overflow: got %b expected 0", overflow);
    end
    tests_run++;
    if (pixel_color !== 16'd2) begin
      fails++; $display("FAIL ppf_entry2: got %0d expected 2", pixel_color);
    end
    tick();
    tests_run++;
    if (start !== 1'b1) begin
      fails++; $display("FAIL ppf_start: got %b expected 1", start);
    end
    tick();        // -> WAIT
  endtask

  // Queue holds colours 3,4,5,6; a push of colour 7 while full is dropped.
  task automatic test_overflow();
    logic [15:0] e;
    write_word(4'd9, 16'd7);
    do_push();
    tests_run++;
    if (overflow !== 1'b1 || q_count !== 3'd4) begin
      fails++; $display("FAIL ovf_set: got ovf=%b count=%0d expected 1/4", overflow, q_count);
    end
    for (int k = 0; k < 4; k++) begin
      e = 16'(k + 3);
      pulse_done();
      repeat (2) tick();  // LOAD, CHECK
      tests_run++;
      if (pixel_color !== e) begin
        fails++; $display("FAIL ovf_drain%0d: got colour %0d expected %0d", k, pixel_color, e);
      end
      repeat (2) tick();  // ISSUE, WAIT
    end
    pulse_done();
    tick();
    tests_run++;
    if (q_empty !== 1'b1 || q_count !== 3'd0 || dbg_state !== ST_IDLE) begin
      fails++; $display("FAIL ovf_empty: got empty=%b count=%0d st=%0d expected 1/0/0", q_empty, q_count, dbg_state);
    end
    tests_run++;
    if (overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_sticky: got %b expected 1", overflow);
    end
    tests_run++;
    if (tri_done_count !== 16'd6) begin
      fails++; $display("FAIL ovf_done_count: got %0d expected 6", tri_done_count);
    end
  endtask

  task automatic test_cull();
    int          s0;
    logic [15:0] exp_done;
    load_stage(16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h0000,
               16'h0200, 16'h0200, 16'h0000, 16'h0009);
    s0 = start_cnt;
    do_push();
    repeat (3) tick();  // E1 LOAD, E2 CHECK, E3
`ifdef DEGENERATE_CULL_EN
    tests_run++;
    if (dbg_state !== ST_IDLE || start !== 1'b0) begin
      fails++; $display("FAIL cull_skip: got st=%0d start=%b expected 0/0", dbg_state, start);
    end
    tests_run++;
    if (cull_count !== 16'd1) begin
      fails++; $display("FAIL cull_count: got %0d expected 1", cull_count);
    end
    repeat (3) tick();
    tests_run++;
    if (start_cnt - s0 !== 0) begin
      fails++; $display("FAIL cull_no_start: got %0d expected 0", start_cnt - s0);
    end
    exp_done = 16'd7;
`else
    tests_run++;
    if (dbg_state !== ST_ISSUE || start !== 1'b1) begin
      fails++; $display("FAIL nocull_issue: got st=%0d start=%b expected %0d/1", dbg_state, start, ST_ISSUE);
    end
    tick();
    pulse_done();
    tests_run++;
    if (cull_count !== 16'd0) begin
      fails++; $display("FAIL nocull_count: got %0d expected 0", cull_count);
    end
    exp_done = 16'd8;
`endif
    load_stage(16'h0020, 16'h0040, 16'h0001, 16'h0200, 16'h0100, 16'h0002,
               16'h0040, 16'h0300, 16'h0003, 16'h000A);
    do_push();
    repeat (3) tick();
    tests_run++;
    if (start !== 1'b1 || pixel_color !== 16'h000A) begin
      fails++; $display("FAIL cull_next_issue: got start=%b colour=%h expected 1/000a", start, pixel_color);
    end
    tick();
    pulse_done();
    tests_run++;
    if (tri_done_count !== exp_done) begin
      fails++; $display("FAIL cull_done_count: got %0d expected %0d", tri_done_count, exp_done);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    load_stage(16'h0020, 16'h0040, 16'h0001, 16'h0200, 16'h0100, 16'h0002,
               16'h0040, 16'h0300, 16'h0003, 16'h000B);
    push = 1'b1;
    repeat (3) tick();
    push = 1'b0;
    repeat (2) tick();
    tests_run++;
    if (dbg_state !== ST_WAIT || q_count !== 3'd2 || v1x !== 16'h0020) begin
      fails++; $display("FAIL rmid_pre: got st=%0d count=%0d v1x=%h expected %0d/2/0020", dbg_state, q_count, v1x, ST_WAIT);
    end
    reset_n = 1'b0;
    #2;  // between clock edges: checks the asynchronous path
    tests_run++;
    if ({v1x, v2y, v3z, pixel_color} !== 64'h0) begin
      fails++; $display("FAIL rmid_vertices: got %h expected 0", {v1x, v2y, v3z, pixel_color});
    end
    tests_run++;
    if ({start, busy, overflow, q_full, q_empty} !== 5'b00001 || q_count !== 3'd0) begin
      fails++; $display("FAIL rmid_flags: got %b count=%0d expected 00001/0", {start, busy, overflow, q_full, q_empty}, q_count);
    end
    tests_run++;
    if ({tri_done_count, cull_count} !== 32'h0 || dbg_state !== ST_IDLE) begin
      fails++; $display("FAIL rmid_counters: got %h st=%0d expected 0/0", {tri_done_count, cull_count}, dbg_state);
    end
    tick();
    reset_n = 1'b1;
    s0 = start_cnt;
    repeat (8) tick();
    tests_run++;
    if (start_cnt - s0 !== 0 || dbg_state !== ST_IDLE) begin
      fails++; $display("FAIL rmid_after: got starts=%0d st=%0d expected 0/0", start_cnt - s0, dbg_state);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n     = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = 4'd0;
    wr_data     = 16'd0;
    push        = 1'b0;
    shader_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    test_reset();
    test_single();
    test_done_idle();
    test_back_to_back();
    test_push_pop_full();
    test_overflow();
    test_cull();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
